boolean_resp_checker: RTL and testbench

- Synthesizable stimulus/response end for the team's 3-input combinational `boolean` blocks.
- Sweeps every input vector onto the DUT inputs, waits a fixed settle time, samples the DUT output and compares it with a parameterized truth table.
- Reports a pass/fail verdict, a mismatch count and the first failing vector, so FPGA bring-up can self-check without a simulator.

---
 rtl/boolean_pkg.sv | 18 +
 rtl/boolean_resp_checker_if.sv | 28 ++
 rtl/boolean_resp_checker_settle_timer.sv | 27 ++
 rtl/boolean_resp_checker.sv | 125 ++++++++++++
 tb/tb_boolean_resp_checker.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/boolean_pkg.sv
// Shared constants and state encoding for the boolean response checker.
package boolean_pkg;

   localparam int unsigned N_IN_DEF = 3;
   localparam int unsigned N_VEC    = 2 ** N_IN_DEF;
   localparam int unsigned CNT_W    = 8;

   // Golden truth tables; bit i is the expected output for vector i.
   localparam logic [N_VEC-1:0] MAJ3 = 8'hE8;
   localparam logic [N_VEC-1:0] XOR3 = 8'h96;

   // Sweep FSM encoding.
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/boolean_resp_checker_if.sv
// Stimulus/response and status bundle between the checker and its environment.
interface boolean_resp_checker_if
   import boolean_pkg::*;
#(
   parameter int unsigned N_IN = N_IN_DEF
);
   logic            start;
   logic            dut_f;
   logic [N_IN-1:0] stim;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   err_count;
   logic            first_err_vld;
   logic [N_IN-1:0] first_err_idx;

   // Environment side: issues start, returns the DUT output.
   modport master (
      output start, dut_f,
      input  stim, busy, done, pass, err_count, first_err_vld, first_err_idx
   );

   // Checker side.
   modport slave (
      input  start, dut_f,
      output stim, busy, done, pass, err_count, first_err_vld, first_err_idx
   );
endinterface

// File: rtl/boolean_resp_checker_settle_timer.sv
// Loadable down-counter with a zero flag, used to hold each vector stable.
module settle_timer
   import boolean_pkg::*;
#(
   parameter int unsigned W = CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero_c
);
   logic [W-1:0] cnt_q;

   // Load has priority; decrement stops at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (load)
         cnt_q <= load_val;
      else if (dec && (cnt_q != '0))
         cnt_q <= cnt_q - W'(1);
   end

   assign zero_c = (cnt_q == '0);
endmodule

// File: rtl/boolean_resp_checker.sv
// Exhaustive truth-table sweep of a combinational boolean block with a verdict.
module boolean_resp_checker
   import boolean_pkg::*;
#(
   parameter int unsigned                N_IN          = N_IN_DEF,
   parameter logic [(2**N_IN)-1:0]       EXPECTED      = MAJ3,
   parameter int unsigned                SETTLE_CYCLES = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   boolean_resp_checker_if.slave bus
);
   localparam int unsigned     NV     = 2 ** N_IN;
   localparam logic [N_IN-1:0] LAST   = N_IN'(NV - 1);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

   logic [1:0]      state_q, state_n;
   logic [N_IN-1:0] stim_q, stim_n;
   logic            busy_q, busy_n;
   logic            done_q, done_n;
   logic            pass_q, pass_n;
   logic [N_IN:0]   err_q, err_n;
   logic            fvld_q, fvld_n;
   logic [N_IN-1:0] fidx_q, fidx_n;
   logic            tmr_load_c, tmr_dec_c, tmr_zero_c;

   settle_timer #(.W(CNT_W)) u_settle_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load_c),
      .load_val (RELOAD),
      .dec      (tmr_dec_c),
      .zero_c   (tmr_zero_c)
   );

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         stim_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fvld_q  <= 1'b0;
         fidx_q  <= '0;
      end else begin
         state_q <= state_n;
         stim_q  <= stim_n;
         busy_q  <= busy_n;
         done_q  <= done_n;
         pass_q  <= pass_n;
         err_q   <= err_n;
         fvld_q  <= fvld_n;
         fidx_q  <= fidx_n;
      end
   end

   // Next-state, compare and statistics update.
   always_comb begin
      state_n    = state_q;
      stim_n     = stim_q;
      busy_n     = busy_q;
      done_n     = done_q;
      pass_n     = pass_q;
      err_n      = err_q;
      fvld_n     = fvld_q;
      fidx_n     = fidx_q;
      tmr_load_c = 1'b0;
      tmr_dec_c  = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (state_q == ST_DONE) begin
               // Verdict publishes a cycle after the last compare, so it sees it.
               busy_n = 1'b0;
               done_n = 1'b1;
               pass_n = (err_q == '0);
            end
            if (bus.start) begin
               state_n    = ST_SETTLE;
               stim_n     = '0;
               tmr_load_c = 1'b1;
               err_n      = '0;
               fvld_n     = 1'b0;
               fidx_n     = '0;
               done_n     = 1'b0;
               pass_n     = 1'b0;
               busy_n     = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (tmr_zero_c)
               state_n = ST_SAMPLE;
            else
               tmr_dec_c = 1'b1;
         end
         ST_SAMPLE: begin
            if (bus.dut_f != EXPECTED[stim_q]) begin
               err_n = err_q + (N_IN+1)'(1);
               if (!fvld_q) begin
                  fvld_n = 1'b1;
                  fidx_n = stim_q;
               end
            end
            if (stim_q == LAST) begin
               state_n = ST_DONE;
            end else begin
               stim_n     = stim_q + N_IN'(1);
               tmr_load_c = 1'b1;
               state_n    = ST_SETTLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign bus.stim          = stim_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.pass          = pass_q;
   assign bus.err_count     = err_q;
   assign bus.first_err_vld = fvld_q;
   assign bus.first_err_idx = fidx_q;
endmodule

// File: tb/tb_boolean_resp_checker.sv
// Self-checking bench: table of DUT behaviours plus reset/restart/settle corner cases.
module tb_boolean_resp_checker;
   import boolean_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   boolean_resp_checker_if #(.N_IN(3)) bus_a ();
   boolean_resp_checker_if #(.N_IN(3)) bus_b ();

   boolean_resp_checker #(.N_IN(3), .EXPECTED(8'hE8), .SETTLE_CYCLES(4)) u_dut_a (
      .clk (clk), .rst_n (rst_n), .bus (bus_a.slave)
   );
   boolean_resp_checker #(.N_IN(3), .EXPECTED(8'hE8), .SETTLE_CYCLES(1)) u_dut_b (
      .clk (clk), .rst_n (rst_n), .bus (bus_b.slave)
   );

   // DUT behaviours: 0 majority, 1 stuck-at-0, 2 inverted majority, 3 xor
   typedef struct {
      int mode;
      int err;
      int vld;
      int idx;
      int pass;
   } vec_t;

   vec_t tbl[4];
   vec_t sb[$];
   int   mode = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   function automatic logic model_f(input int m, input logic [2:0] v);
      logic maj;
      maj = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
      case (m)
         0:       return maj;
         1:       return 1'b0;
         2:       return ~maj;
         default: return XOR3[v];
      endcase
   endfunction

   always_comb bus_a.dut_f = model_f(mode, bus_a.stim);
   always_comb bus_b.dut_f = model_f(0, bus_b.stim);

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   task automatic check_zero_a(input string tag);
      check({tag, "_stim"}, int'(bus_a.stim), 0);
      check({tag, "_busy"}, int'(bus_a.busy), 0);
      check({tag, "_done"}, int'(bus_a.done), 0);
      check({tag, "_pass"}, int'(bus_a.pass), 0);
      check({tag, "_err"},  int'(bus_a.err_count), 0);
      check({tag, "_vld"},  int'(bus_a.first_err_vld), 0);
      check({tag, "_idx"},  int'(bus_a.first_err_idx), 0);
   endtask

   // Full sweep on instance A; inj_edge>0 pulses start again at that edge.
   task automatic sweep_a(input vec_t row, input int inj_edge);
      int   done_edge;
      int   stim_bad;
      int   busy_bad;
      int   ev;
      vec_t exp;
      @(negedge clk);
      mode = row.mode;
      bus_a.start = 1'b1;
      sb.push_back(row);
      @(negedge clk);
      bus_a.start = 1'b0;
      check("busy_after_start", int'(bus_a.busy), 1);
      check("done_cleared", int'(bus_a.done), 0);
      check("stim_first", int'(bus_a.stim), 0);
      done_edge = -1;
      stim_bad  = 0;
      busy_bad  = 0;
      for (int k = 1; k <= 60; k++) begin
         if (k == inj_edge) bus_a.start = 1'b1;
         @(negedge clk);
         bus_a.start = 1'b0;
         if (bus_a.done) begin
            done_edge = k;
            break;
         end
         ev = (k / 5 > 7) ? 7 : k / 5;
         if (int'(bus_a.stim) != ev) stim_bad++;
         if (!bus_a.busy) busy_bad++;
      end
      check("done_edge", done_edge, 41);
      check("stim_seq_errors", stim_bad, 0);
      check("busy_drop_errors", busy_bad, 0);
      if (sb.size() == 0) begin
         check("scoreboard_empty", 0, 1);
      end else begin
         exp = sb.pop_front();
         check("err_count", int'(bus_a.err_count), exp.err);
         check("first_err_vld", int'(bus_a.first_err_vld), exp.vld);
         check("first_err_idx", int'(bus_a.first_err_idx), exp.idx);
         check("pass", int'(bus_a.pass), exp.pass);
      end
      check("busy_in_done", int'(bus_a.busy), 0);
      check("stim_last", int'(bus_a.stim), 7);
   endtask

   initial begin
      int done_edge_b;
      int stim_bad_b;
      int ev;

      tbl[0] = '{mode: 0, err: 0, vld: 0, idx: 0, pass: 1};
      tbl[1] = '{mode: 1, err: 4, vld: 1, idx: 3, pass: 0};
      tbl[2] = '{mode: 2, err: 8, vld: 1, idx: 0, pass: 0};
      tbl[3] = '{mode: 3, err: 6, vld: 1, idx: 1, pass: 0};

      bus_a.start = 1'b0;
      bus_b.start = 1'b0;

      #12;
      check_zero_a("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Behaviour table; consecutive rows also exercise restart from DONE.
      for (int i = 0; i < 4; i++) sweep_a(tbl[i], 0);

      // Start pulsed while busy must not disturb timing or result.
      sweep_a(tbl[0], 10);
      // Plain re-run from DONE gives identical results.
      sweep_a(tbl[0], 0);

      // Asynchronous reset in the middle of a sweep.
      @(negedge clk);
      mode = 0;
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      repeat (19) @(negedge clk);
      @(posedge clk);
      #2;
      check("pre_reset_busy", int'(bus_a.busy), 1);
      check("pre_reset_stim", int'(bus_a.stim), 4);
      rst_n = 1'b0;
      #1;
      check_zero_a("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      sweep_a(tbl[0], 0);

      // Short settle time on instance B: each vector held 2 cycles.
      @(negedge clk);
      bus_b.start = 1'b1;
      @(negedge clk);
      bus_b.start = 1'b0;
      check("b_stim_first", int'(bus_b.stim), 0);
      done_edge_b = -1;
      stim_bad_b  = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus_b.done) begin
            done_edge_b = k;
            break;
         end
         ev = (k / 2 > 7) ? 7 : k / 2;
         if (int'(bus_b.stim) != ev) stim_bad_b++;
      end
      check("b_done_edge", done_edge_b, 17);
      check("b_stim_seq_errors", stim_bad_b, 0);
      check("b_pass", int'(bus_b.pass), 1);
      check("b_err_count", int'(bus_b.err_count), 0);
      check("b_stim_last", int'(bus_b.stim), 7);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
